ysyx_22040125_ifu: RTL and testbench
====================================

YSYX_22040125_IFU -- requirements
Module: ysyx_22040125_IFU

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL give the first fetch address after reset.
REQ-002 Constant NOP, 32'h0000_0013, SHALL be the reset and idle value of inst.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 imem_req_valid  out  1  SHALL indicate a fetch request.
REQ-006 imem_req_ready  in  1  SHALL indicate the instruction memory accepts the request.
REQ-007 imem_addr  out  64  SHALL be the fetch address, equal to pc.
REQ-008 imem_rsp_valid  in  1  SHALL indicate imem_rsp_data is valid; responses are always accepted.
REQ-009 imem_rsp_data  in  32  SHALL be the fetched instruction word.
REQ-010 inst_valid  out  1  SHALL indicate inst and pc are presented to the decoder.
REQ-011 inst_ready  in  1  SHALL indicate the decoder consumes inst this cycle.
REQ-012 inst  out  32  SHALL be the instruction word feeding the decoder.
REQ-013 pc  out  64  SHALL be the address of inst.
REQ-014 redir_valid  in  1  SHALL request a control-flow redirect (jal, jalr, taken branch).
REQ-015 redir_pc  in  64  SHALL be the redirect target.
REQ-016 halt  in  1  SHALL request stop of fetching (ebreak retired).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, HALT; imem_req_valid = (state==REQ); inst_valid = (state==HOLD).
REQ-018 IDLE -> REQ unconditionally after one cycle.
REQ-019 REQ -> WAIT when imem_req_ready=1; otherwise stay in REQ with imem_addr stable.
REQ-020 WAIT: on imem_rsp_valid, inst <= imem_rsp_data and -> HOLD; minimum latency is acceptance at cycle t, response at t+1, inst_valid at t+2.
REQ-021 Only one request SHALL be outstanding; no request is issued in WAIT or HOLD.
REQ-022 HOLD: when inst_ready=1 and redir_valid=0, pc <= pc + 4 (64-bit modulo, 0xFFFF_FFFF_FFFF_FFFC wraps to 0) and -> REQ.
REQ-023 inst and pc SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-024 A redirect in REQ or HOLD SHALL set pc <= {redir_pc[63:2],2'b00} and -> REQ; redirect overrides a simultaneous inst_ready handshake (the held instruction is discarded and the decoder must ignore that handshake).
REQ-025 A redirect in WAIT SHALL latch the target and set a drop flag; the pending response is discarded, then -> REQ at the target.
REQ-026 A redirect arriving in the same cycle as imem_rsp_valid in WAIT SHALL discard that response and -> REQ at the target.
REQ-027 In REQ, a redirect in the same cycle as imem_req_ready=1 SHALL treat the request as issued: -> WAIT with the drop flag set.
REQ-028 halt SHALL take priority over redirect; halt in IDLE, REQ (not accepted) or HOLD -> HALT; in WAIT, the response is awaited and discarded, then -> HALT.
REQ-029 HALT SHALL be left only by reset; inst_valid and imem_req_valid are 0 in HALT.
REQ-030 inst and imem_rsp_data SHALL be 32 bits; pc arithmetic SHALL be 64 bits.

Reset
REQ-031 While rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, inst=NOP, drop flag=0, imem_req_valid=0, inst_valid=0.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request; a late response arriving in IDLE or REQ is ignored.

Structure
REQ-033 FSM state encodings, RESET_PC and NOP SHALL be defined in the shared ysyx_22040125 config header used by all pipeline stages.
REQ-034 No sub-module is required; the FSM, pc register and inst register are local.

Verification
REQ-035 Reset release with ready memory (1-cycle response) -> first imem_addr 0x8000_0000; inst_valid at cycle 3; second fetch address 0x8000_0004 after inst_ready.
REQ-036 inst_ready=0 for 5 cycles in HOLD -> inst and pc stable, no new imem_req_valid.
REQ-037 redir_valid with redir_pc 0x8000_0102 during WAIT -> response dropped, next imem_addr 0x8000_0100, no inst_valid for the dropped word.
REQ-038 redir_valid and inst_ready together in HOLD at pc 0x8000_0010 -> next imem_addr is the redirect target, not 0x8000_0014.
REQ-039 pc 0xFFFF_FFFF_FFFF_FFFC consumed -> next imem_addr 0x0.
REQ-040 halt in WAIT -> response consumed silently, HALT entered, imem_req_valid stays 0 until rst_n=0.

Source files
------------

// File: rtl/ysyx_22040125_pkg.sv
// Shared ysyx_22040125 pipeline configuration.
// Fetch FSM encodings, reset vector and the canonical NOP.
package ysyx_22040125_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } ifu_state_t;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    function automatic logic [63:0] align_pc(input logic [63:0] a);
        return a & ~64'd3;
    endfunction

endpackage

// File: rtl/ysyx_22040125_ifu.sv
// Instruction fetch unit: one outstanding imem request,
// redirect/halt handling and a held instruction slot for decode.
module ysyx_22040125_ifu
    import ysyx_22040125_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] pc,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    input  logic        halt
);

    ifu_state_t  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;
    logic        halt_q, halt_d;
    logic [63:0] redir_tgt;

    assign redir_tgt = align_pc(redir_pc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            drop_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        halt_d  = halt_q;
        unique case (state_q)
            IDLE: begin
                state_d = halt ? HALT : REQ;
            end
            REQ: begin
                if (halt) begin
                    // an accepted request must still be drained
                    if (imem_req_ready) begin
                        state_d = WAIT;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = HALT;
                    end
                end else if (redir_valid) begin
                    pc_d = redir_tgt;
                    if (imem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (halt || halt_q) begin
                    if (imem_rsp_valid) state_d = HALT;
                    else                halt_d  = 1'b1;
                end else if (redir_valid) begin
                    pc_d = redir_tgt;
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (halt) begin
                    state_d = HALT;
                end else if (redir_valid) begin
                    pc_d    = redir_tgt;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = REQ;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign inst_valid     = (state_q == HOLD);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;

endmodule

// File: tb/tb_ysyx_22040125_ifu.sv
// Directed bench for the fetch unit with immediate assertions.
module tb_ysyx_22040125_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        halt;

    int pass_cnt = 0;
    int total_cnt = 0;

    ysyx_22040125_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redir_valid    = 1'b0;
        redir_pc       = 64'h0;
        halt           = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'h13);
        check("rst_pc", pc, 64'h8000_0000);

        // first fetch: IDLE, REQ, WAIT, HOLD
        rst_n = 1'b1;
        tick();
        check("f0_req_valid", 64'(imem_req_valid), 64'd1);
        check("f0_addr", imem_addr, 64'h8000_0000);
        imem_req_ready = 1'b1;
        tick();
        check("f0_wait_noreq", 64'(imem_req_valid), 64'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        tick();
        check("f0_inst_valid", 64'(inst_valid), 64'd1);
        check("f0_inst", 64'(inst), 64'h0010_0093);
        check("f0_pc", pc, 64'h8000_0000);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hFFFF_FFFF;

        // decoder stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(inst_valid), 64'd1);
            check("stall_noreq", 64'(imem_req_valid), 64'd0);
            check("stall_inst", 64'(inst), 64'h0010_0093);
            check("stall_pc", pc, 64'h8000_0000);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("f1_req_valid", 64'(imem_req_valid), 64'd1);
        check("f1_addr", imem_addr, 64'h8000_0004);

        // memory not ready: request held
        tick();
        check("reqwait_valid", 64'(imem_req_valid), 64'd1);
        check("reqwait_addr", imem_addr, 64'h8000_0004);

        // redirect during WAIT drops the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0102;
        tick();
        redir_valid = 1'b0;
        check("rw_noreq", 64'(imem_req_valid), 64'd0);
        check("rw_noinst", 64'(inst_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        check("rw_dropped", 64'(inst_valid), 64'd0);
        check("rw_req_valid", 64'(imem_req_valid), 64'd1);
        check("rw_addr", imem_addr, 64'h8000_0100);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0033;
        tick();
        imem_rsp_valid = 1'b0;
        check("rw_hold_pc", pc, 64'h8000_0100);
        check("rw_hold_inst", 64'(inst), 64'h0000_0033);

        // redirect in HOLD to 0x8000_0010, then refetch
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0010;
        tick();
        redir_valid = 1'b0;
        check("rh_addr", imem_addr, 64'h8000_0010);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_006F;
        tick();
        imem_rsp_valid = 1'b0;
        check("rh_pc", pc, 64'h8000_0010);

        // redirect beats simultaneous inst_ready
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0200;
        tick();
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        check("rdy_redir_addr", imem_addr, 64'h8000_0200);
        check("rdy_redir_req", 64'(imem_req_valid), 64'd1);

        // redirect in REQ (not accepted) to top of address space
        redir_valid = 1'b1;
        redir_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redir_valid = 1'b0;
        check("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        check("wrap_hold_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("wrap_addr", imem_addr, 64'h0);

        // redirect together with the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redir_valid    = 1'b1;
        redir_pc       = 64'h300;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        tick();
        redir_valid    = 1'b0;
        imem_rsp_valid = 1'b0;
        check("rsp_redir_noinst", 64'(inst_valid), 64'd0);
        check("rsp_redir_addr", imem_addr, 64'h300);

        // redirect together with request acceptance
        redir_valid    = 1'b1;
        redir_pc       = 64'h400;
        imem_req_ready = 1'b1;
        tick();
        redir_valid    = 1'b0;
        imem_req_ready = 1'b0;
        check("acc_redir_wait", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
        tick();
        imem_rsp_valid = 1'b0;
        check("acc_redir_noinst", 64'(inst_valid), 64'd0);
        check("acc_redir_addr", imem_addr, 64'h400);

        // halt in WAIT: drain response, then HALT forever
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("hw_noreq", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0003;
        tick();
        imem_rsp_valid = 1'b0;
        check("halt_noinst", 64'(inst_valid), 64'd0);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_noreq", 64'(imem_req_valid), 64'd0);
            check("halt_noinst", 64'(inst_valid), 64'd0);
        end
        idle_inputs();

        // reset leaves HALT; a late response in REQ is ignored
        rst_n = 1'b0;
        tick();
        check("rst2_pc", pc, 64'h8000_0000);
        check("rst2_inst", 64'(inst), 64'h13);
        rst_n = 1'b1;
        tick();
        check("rst2_req", 64'(imem_req_valid), 64'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0004;
        tick();
        imem_rsp_valid = 1'b0;
        check("late_rsp_req", 64'(imem_req_valid), 64'd1);
        check("late_rsp_noinst", 64'(inst_valid), 64'd0);
        check("late_rsp_inst", 64'(inst), 64'h13);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
